// File: rtl/dsp_arith_pkg.sv
// Shared types for dsp_arith_unit: op encodings, FSM states, multiplier slice width.
// No logic, no latency.
// No backpressure; types only.
package dsp_arith_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MULL = 2'b10,
    OP_MULH = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ADDSUB = 2'b01,
    ST_MUL    = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  function automatic logic is_mul(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/dsp_arith_mul16.sv
// Unsigned 16x16 -> 32 multiplier; one SB_MAC16 on iCE40, behavioural elsewhere.
// Latency: combinational, all MAC registers bypassed.
// No backpressure; pure function of a and b.
module dsp_mul16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

`ifdef SYNTHESIS
  SB_MAC16 #(
    .NEG_TRIGGER              (1'b0),
    .C_REG                    (1'b0),
    .A_REG                    (1'b0),
    .B_REG                    (1'b0),
    .D_REG                    (1'b0),
    .TOP_8x8_MULT_REG         (1'b0),
    .BOT_8x8_MULT_REG         (1'b0),
    .PIPELINE_16x16_MULT_REG1 (1'b0),
    .PIPELINE_16x16_MULT_REG2 (1'b0),
    .TOPOUTPUT_SELECT         (2'b11),
    .TOPADDSUB_LOWERINPUT     (2'b00),
    .TOPADDSUB_UPPERINPUT     (1'b0),
    .TOPADDSUB_CARRYSELECT    (2'b00),
    .BOTOUTPUT_SELECT         (2'b11),
    .BOTADDSUB_LOWERINPUT     (2'b00),
    .BOTADDSUB_UPPERINPUT     (1'b0),
    .BOTADDSUB_CARRYSELECT    (2'b00),
    .MODE_8x8                 (1'b0),
    .A_SIGNED                 (1'b0),
    .B_SIGNED                 (1'b0)
  ) u_mac (
    .CLK        (1'b0),
    .CE         (1'b0),
    .C          (16'h0000),
    .A          (a),
    .B          (b),
    .D          (16'h0000),
    .AHOLD      (1'b0),
    .BHOLD      (1'b0),
    .CHOLD      (1'b0),
    .DHOLD      (1'b0),
    .IRSTTOP    (1'b0),
    .IRSTBOT    (1'b0),
    .ORSTTOP    (1'b0),
    .ORSTBOT    (1'b0),
    .OLOADTOP   (1'b0),
    .OLOADBOT   (1'b0),
    .ADDSUBTOP  (1'b0),
    .ADDSUBBOT  (1'b0),
    .OHOLDTOP   (1'b0),
    .OHOLDBOT   (1'b0),
    .CI         (1'b0),
    .ACCUMCI    (1'b0),
    .SIGNEXTIN  (1'b0),
    .O          (p),
    .CO         (),
    .ACCUMCO    (),
    .SIGNEXTOUT ()
  );
`else
  assign p = 32'(a) * 32'(b);
`endif

endmodule

// File: rtl/dsp_arith_unit.sv
// Sequential unsigned ADD/SUB/MULL/MULH on WIDTH-bit operands using one 16x16 multiplier slice.
// Latency: ADD/SUB 1 cycle, MUL (WIDTH/16)^2 cycles; MULH needs DSP_ARITH_MULH_EN, else op 11 acts as MULL.
// Backpressure: in_ready only in IDLE; result/carry held in DONE until out_ready.
module dsp_arith_unit
  import dsp_arith_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
`ifdef DSP_ARITH_MULH_EN
  localparam int ACC_W = 2 * WIDTH;
`else
  localparam int ACC_W = WIDTH;
`endif

  state_e               state, state_nxt;
  op_e                  op_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [ACC_W-1:0]     acc, acc_nxt;
  logic [CNT_W-1:0]     i_q, j_q;
  logic [SLICE_W-1:0]   a_sl, b_sl;
  logic [2*SLICE_W-1:0] prod;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     mul_res;
  logic [WIDTH-1:0]     result_q;
  logic                 carry_q;
  logic                 last_pair;
  logic                 pp_en;
  logic                 accept;
  int unsigned          sh;

  assign accept    = in_valid && (state == ST_IDLE);
  assign last_pair = (i_q == CNT_W'(N - 1)) && (j_q == CNT_W'(N - 1));
  assign a_sl      = a_q[SLICE_W*i_q +: SLICE_W];
  assign b_sl      = b_q[SLICE_W*j_q +: SLICE_W];

  dsp_mul16 u_mul (
    .a (a_sl),
    .b (b_sl),
    .p (prod)
  );

  always_comb begin
    sum = '0;
    if (op_q == OP_SUB)
      sum = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
    else
      sum = {1'b0, a_q} + {1'b0, b_q};
  end

  // Without the high half, products landing wholly above WIDTH are dropped but still take their cycle.
  always_comb begin
    sh = SLICE_W * (32'(i_q) + 32'(j_q));
`ifdef DSP_ARITH_MULH_EN
    pp_en = 1'b1;
`else
    pp_en = (sh < WIDTH);
`endif
    acc_nxt = acc;
    if (pp_en)
      acc_nxt = acc + (ACC_W'(prod) << sh);
  end

  always_comb begin
`ifdef DSP_ARITH_MULH_EN
    if (op_q == OP_MULH)
      mul_res = acc_nxt[ACC_W-1:WIDTH];
    else
      mul_res = acc_nxt[WIDTH-1:0];
`else
    mul_res = acc_nxt;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (in_valid) state_nxt = is_mul(op) ? ST_MUL : ST_ADDSUB;
      ST_ADDSUB: state_nxt = ST_DONE;
      ST_MUL:    if (last_pair) state_nxt = ST_DONE;
      ST_DONE:   if (out_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  // The final partial product is folded in on the same edge that registers the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q <= op_e'(op);
            a_q  <= a;
            b_q  <= b;
            acc  <= '0;
            i_q  <= '0;
            j_q  <= '0;
          end
        end
        ST_ADDSUB: begin
          result_q <= sum[WIDTH-1:0];
          carry_q  <= sum[WIDTH];
        end
        ST_MUL: begin
          acc <= acc_nxt;
          if (j_q == CNT_W'(N - 1)) begin
            j_q <= '0;
            i_q <= i_q + CNT_W'(1);
          end else begin
            j_q <= j_q + CNT_W'(1);
          end
          if (last_pair) begin
            result_q <= mul_res;
            carry_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign carry  = carry_q;

endmodule

// File: tb/tb_dsp_arith_unit.sv
// Directed self-checking bench for dsp_arith_unit (WIDTH=32); MULH expectations follow DSP_ARITH_MULH_EN.
module tb_dsp_arith_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry;

  int n_checks = 0;
  int n_fail   = 0;

  dsp_arith_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one request and returns the number of edges after acceptance until out_valid.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    check({tag, " out_valid"}, 64'(out_valid), 64'd0);
  endtask

  task automatic op_test(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp_res,
                         input logic exp_c, input int exp_lat);
    int lat;
    run_op(o, x, y, lat);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, 64'(result), 64'(exp_res));
    check({tag, " carry"}, 64'(carry), 64'(exp_c));
    finish_op(tag);
  endtask

  logic [31:0] exp_mulh_ff, exp_mulh_10k, exp_mulh_big;

  initial begin
    int lat;
`ifdef DSP_ARITH_MULH_EN
    exp_mulh_ff  = 32'hFFFF_FFFE;
    exp_mulh_10k = 32'h0000_0001;
    exp_mulh_big = 32'h0000_0002;
`else
    exp_mulh_ff  = 32'h0000_0001;
    exp_mulh_10k = 32'h0000_0000;
    exp_mulh_big = 32'h0000_0000;
`endif
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    step();
    step();
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset carry", 64'(carry), 64'd0);
    rst = 1'b0;

    op_test("add wrap",   2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1);
    op_test("sub borrow", 2'b01, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1);
    op_test("sub nobrw",  2'b01, 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 1'b1, 1);
    op_test("mull ff",    2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4);
    op_test("mulh ff",    2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, exp_mulh_ff,   1'b0, 4);
    op_test("mull 10k",   2'b10, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 4);
    op_test("mulh 10k",   2'b11, 32'h0001_0000, 32'h0001_0000, exp_mulh_10k,  1'b0, 4);
    op_test("mull cross", 2'b10, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0, 4);
    op_test("mull small", 2'b10, 32'h1234_5678, 32'h0000_0009, 32'hA3D7_0A38, 1'b0, 4);
    op_test("mulh big",   2'b11, 32'h8000_0000, 32'h0000_0004, exp_mulh_big,  1'b0, 4);

    // Consumer stalls; a request during DONE must be ignored.
    run_op(2'b00, 32'd3, 32'd4, lat);
    check("hold latency", 64'(lat), 64'd1);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        in_valid = 1'b1;
        op = 2'b00;
        a = 32'd100;
        b = 32'd1;
      end
      step();
      in_valid = 1'b0;
      check("hold result", 64'(result), 64'd7);
      check("hold in_ready", 64'(in_ready), 64'd0);
      check("hold out_valid", 64'(out_valid), 64'd1);
    end
    finish_op("hold release");
    step();
    check("hold no ghost", 64'(out_valid), 64'd0);
    check("hold idle", 64'(in_ready), 64'd1);

    // Reset sampled on E2 of a multiply.
    in_valid = 1'b1;
    op = 2'b10;
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd1);
    check("midrst result", 64'(result), 64'd0);
    op_test("post rst add", 2'b00, 32'd1, 32'd1, 32'd2, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
